// File: rtl/memory_responder.sv
// Single-port memory arbiter: serves data and instruction requests against a backend RAM,
// data first, with a per-access wait timeout that raises a sticky error flag.
module memory_responder #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] imemload,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_done,
  output logic        err
);

  typedef enum logic [2:0] {StIdle, StDacc, StIacc, StDresp, StIresp} state_e;

  // Count value seen on the last permitted wait cycle of an access.
  localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] imemload_q;
  logic [31:0] dmemload_q;
  logic        err_q;
  logic        dreq;

  assign dreq = dmemREN | dmemWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      imemload_q <= '0;
      dmemload_q <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dreq) begin
            state_q <= StDacc;
            cnt_q   <= '0;
          end else if (imemREN) begin
            state_q <= StIacc;
            cnt_q   <= '0;
          end
        end
        StDacc: begin
          // A withdrawn request wins over a completion arriving in the same cycle.
          if (!dreq) begin
            state_q <= StIdle;
          end else if (ram_done) begin
            state_q <= StDresp;
            if (dmemREN) dmemload_q <= ramload;
          end else if (cnt_q == LastCnt) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StIacc: begin
          if (!imemREN) begin
            state_q <= StIdle;
          end else if (ram_done) begin
            state_q    <= StIresp;
            imemload_q <= ramload;
          end else if (cnt_q == LastCnt) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDresp, StIresp: state_q <= StIdle;
        default:          state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (state_q == StDacc) begin
      ramREN   = dmemREN;
      ramWEN   = dmemWEN & ~dmemREN;
      ramaddr  = dmemaddr;
      ramstore = dmemstore;
    end else if (state_q == StIacc) begin
      ramREN  = 1'b1;
      ramaddr = imemaddr;
    end
  end

  assign dhit     = (state_q == StDresp);
  assign ihit     = (state_q == StIresp);
  assign imemload = imemload_q;
  assign dmemload = dmemload_q;
  assign err      = err_q;

endmodule
